// File: rtl/pdm_modulator.sv
// pdm_modulator: interpolating first-order delta-sigma modulator, one PDM bit per clock, OSR bits per sample
module pdm_modulator #(
  parameter int DW  = 8,
  parameter int OSR = 64
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_enable,
  input  logic [DW-1:0] i_in_data,
  input  logic          i_in_valid,
  output logic          o_in_ready,
  output logic          o_out,
  output logic          o_sample_tick,
  output logic          o_underrun
);
  localparam int PW = (OSR > 1) ? $clog2(OSR) : 1;
  localparam logic [PW-1:0] LAST = PW'(OSR - 1);
  typedef enum logic [1:0] {IDLE, PRIME, RUN} state_t;
  state_t          r_state, w_state_nxt;
  logic [DW-1:0]   r_acc, r_cur, r_nxt;
  logic [PW-1:0]   r_phase;
  logic            r_nxt_valid, r_out, r_tick, r_underrun;
  logic [DW:0]     w_sum;
  logic            w_hs, w_bnd;
  assign o_in_ready    = (r_state != IDLE) && !r_nxt_valid;
  assign w_hs          = i_in_valid && o_in_ready;
  assign w_sum         = {1'b0, r_acc} + {1'b0, r_cur};
  assign w_bnd         = r_phase == LAST;
  assign o_out         = r_out;
  assign o_sample_tick = r_tick;
  assign o_underrun    = r_underrun;
  always_comb begin
    w_state_nxt = !i_enable ? IDLE :
                  (r_state == IDLE) ? PRIME :
                  (r_state == PRIME && r_nxt_valid) ? RUN : r_state;
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_acc       <= '0;
      r_cur       <= '0;
      r_nxt       <= '0;
      r_phase     <= '0;
      r_nxt_valid <= 1'b0;
      r_out       <= 1'b0;
      r_tick      <= 1'b0;
      r_underrun  <= 1'b0;
    end else begin
      r_out      <= 1'b0;
      r_tick     <= 1'b0;
      r_underrun <= 1'b0;
      if (r_state == RUN && i_enable) begin
        // acc keeps running across boundaries so the noise shaping stays continuous
        {r_out, r_acc} <= w_sum;
        r_phase        <= w_bnd ? '0 : r_phase + 1'b1;
        r_tick         <= w_bnd;
        r_underrun     <= w_bnd && !r_nxt_valid;
        if (w_bnd && r_nxt_valid) begin
          r_cur       <= r_nxt;
          r_nxt_valid <= 1'b0;
        end else if (w_hs) begin
          r_nxt       <= i_in_data;
          r_nxt_valid <= 1'b1;
        end
      end else if (r_state == PRIME && i_enable) begin
        if (r_nxt_valid) begin
          r_cur       <= r_nxt;
          r_nxt_valid <= 1'b0;
          r_acc       <= '0;
          r_phase     <= '0;
        end else if (w_hs) begin
          r_nxt       <= i_in_data;
          r_nxt_valid <= 1'b1;
        end
      end else begin
        r_acc       <= '0;
        r_phase     <= '0;
        r_nxt_valid <= 1'b0;
      end
    end
  end
endmodule
